// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: pointer sizing, read-mode enum and default thresholds.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    localparam int DEF_AE_THRESH = 2;

    // One extra MSB beyond the address distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int def_af_thresh(input int depth);
        return depth - 2;
    endfunction

endpackage

// File: rtl/d1ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module d1ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/d1fifo.sv
// Synchronous FIFO with wrap-bit pointers, selectable registered or first-word-fall-through
// read, occupancy flags derived only from registered pointers, and sticky error flags.
module d1fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 32,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = def_af_thresh(DEPTH),
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        push,
    input  logic [WIDTH-1:0]            wdata,
    input  logic                        pop,
    output logic [WIDTH-1:0]            rdata,
    output logic                        rvalid,
    output logic                        full,
    output logic                        empty,
    output logic                        al_full,
    output logic                        al_empty,
    output logic [ptr_width(DEPTH)-1:0] count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int         PW   = ptr_width(DEPTH);
    localparam int         AW   = PW - 1;
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             ren, wen;
    logic [WIDTH-1:0] ram_rdata;

    assign count    = wr_ptr_q - rd_ptr_q;
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign al_full  = (count >= AF_C);
    assign al_empty = (count <= AE_C);

    // A pop frees a slot in the same cycle, so push is accepted at full when paired with a pop.
    assign ren = pop && !empty;
    assign wen = push && (!full || ren);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q | (push & full & ~ren);
        unf_d    = unf_q | (pop & empty);
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (wen) wr_ptr_d = wr_ptr_q + 1'b1;
            if (ren) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;

    d1ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wen && !clr),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    // rvalid qualifies rdata: a one-cycle pulse after each accepted pop in registered mode,
    // or a level meaning "rdata is the head word and pop consumes it" in fall-through mode.
    if (MODE == FIFO_STD) begin : g_std
        logic [WIDTH-1:0] rdata_q, rdata_d;
        logic             rvalid_q, rvalid_d;

        always_comb begin
            rdata_d  = rdata_q;
            rvalid_d = 1'b0;
            if (ren && !clr) begin
                rdata_d  = ram_rdata;
                rvalid_d = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rdata_q  <= rdata_d;
                rvalid_q <= rvalid_d;
            end
        end

        assign rdata  = rdata_q;
        assign rvalid = rvalid_q;
    end else begin : g_fwft
        assign rdata  = empty ? '0 : ram_rdata;
        assign rvalid = !empty;
    end

endmodule

// File: tb/tb_d1fifo.sv
// Bench for d1fifo: a registered-read and a fall-through instance (DEPTH 8, WIDTH 16, AF 6, AE 2)
// driven by directed vectors; read data is checked against expected queues by monitors.
module tb_d1fifo;

    localparam int W = 16;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;

    logic          clr0, push0, pop0;
    logic [W-1:0]  wdata0, rdata0;
    logic          rvalid0, full0, empty0, afull0, aempty0, ovf0, unf0;
    logic [CW-1:0] count0;

    logic          clr1, push1, pop1;
    logic [W-1:0]  wdata1, rdata1;
    logic          rvalid1, full1, empty1, afull1, aempty1, ovf1, unf1;
    logic [CW-1:0] count1;

    logic [W-1:0]  exp_q0[$];
    logic [W-1:0]  exp_q1[$];
    int            n_cmp;
    int            n_err;
    int            rvalid_cnt0;

    d1fifo #(.WIDTH(16), .DEPTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr0), .push(push0), .wdata(wdata0), .pop(pop0),
        .rdata(rdata0), .rvalid(rvalid0), .full(full0), .empty(empty0), .al_full(afull0),
        .al_empty(aempty0), .count(count0), .overflow(ovf0), .underflow(unf0)
    );

    d1fifo #(.WIDTH(16), .DEPTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr1), .push(push1), .wdata(wdata1), .pop(pop1),
        .rdata(rdata1), .rvalid(rvalid1), .full(full1), .empty(empty1), .al_full(afull1),
        .al_empty(aempty1), .count(count1), .overflow(ovf1), .underflow(unf1)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word0(input logic [W-1:0] d, input bit expect_out);
        push0  = 1'b1;
        wdata0 = d;
        if (expect_out) exp_q0.push_back(d);
    endtask

    // registered-read monitor: every rvalid pulse must deliver the next expected word
    always @(negedge clk) begin
        if (rst_n && rvalid0) begin
            rvalid_cnt0++;
            if (exp_q0.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd0_unexpected: got 0x%0h, expected no read (t=%0t)", rdata0, $time);
            end else begin
                chk("rd0_data", rdata0, exp_q0.pop_front());
            end
        end
    end

    // fall-through monitor: a pop while rvalid consumes the presented word
    always @(negedge clk) begin
        if (rst_n && pop1 && rvalid1) begin
            if (exp_q1.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd1_unexpected: got 0x%0h, expected no read (t=%0t)", rdata1, $time);
            end else begin
                chk("rd1_data", rdata1, exp_q1.pop_front());
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rvalid_cnt0 = 0;
        rst_n = 1'b0;
        {clr0, push0, pop0, wdata0} = '0;
        {clr1, push1, pop1, wdata1} = '0;

        #3;
        chk("rst_count0", count0, 0);
        chk("rst_empty0", empty0, 1);
        chk("rst_aempty0", aempty0, 1);
        chk("rst_full0", full0, 0);
        chk("rst_afull0", afull0, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_flags0", {ovf0, unf0}, 0);
        chk("rst_rvalid1", rvalid1, 0);
        chk("rst_rdata1", rdata1, 0);

        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("idle_count0", count0, 0);
        chk("idle_empty0", empty0, 1);
        chk("idle_aempty0", aempty0, 1);
        chk("idle_full0", full0, 0);
        chk("idle_rvalid0", rvalid0, 0);

        // fill to full, then one dropped push
        for (int i = 1; i <= 8; i++) begin
            push_word0(W'(i), 1'b1);
            step();
            chk("fill_count", count0, i);
            chk("fill_afull", afull0, (i >= 6) ? 1 : 0);
            chk("fill_aempty", aempty0, (i <= 2) ? 1 : 0);
            chk("fill_full", full0, (i == 8) ? 1 : 0);
        end
        push_word0(16'h0099, 1'b0);
        step();
        push0 = 1'b0;
        chk("ovf_count", count0, 8);
        chk("ovf_full", full0, 1);
        chk("ovf_flag", ovf0, 1);

        // drain in order, each word one cycle after its pop
        rvalid_cnt0 = 0;
        pop0 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("drain_rvalid", rvalid0, 1);
            chk("drain_count", count0, 8 - i);
        end
        step();
        pop0 = 1'b0;
        chk("unf_flag", unf0, 1);
        chk("unf_rvalid", rvalid0, 0);
        chk("unf_count", count0, 0);
        chk("ovf_sticky", ovf0, 1);
        #4 chk("drain_pulses", rvalid_cnt0, 8);
        step();
        chk("rdata_hold", rdata0, 16'h0008);

        clr0 = 1'b1;
        step();
        clr0 = 1'b0;
        chk("clr_flags", {ovf0, unf0}, 0);

        // push+pop at full keeps count at 8 and the new word goes last
        for (int i = 0; i < 8; i++) begin
            push_word0(16'h0011 + W'(i), 1'b1);
            step();
        end
        chk("refill_full", full0, 1);
        push_word0(16'hAAAA, 1'b1);
        pop0 = 1'b1;
        step();
        push0 = 1'b0;
        chk("pp_full_count", count0, 8);
        chk("pp_full_ovf", ovf0, 0);
        for (int i = 0; i < 8; i++) step();
        pop0 = 1'b0;
        step();
        chk("pp_drain_empty", empty0, 1);
        chk("pp_drain_qsize", exp_q0.size(), 0);

        // clr with push at count 5 after an underflow
        pop0 = 1'b1;
        step();
        pop0 = 1'b0;
        chk("unf2_flag", unf0, 1);
        for (int i = 0; i < 5; i++) begin
            push_word0(16'h0300 + W'(i), 1'b0);
            step();
        end
        chk("pre_clr_count", count0, 5);
        push_word0(16'h0BAD, 1'b0);
        clr0 = 1'b1;
        step();
        clr0 = 1'b0;
        push0 = 1'b0;
        chk("clr_count", count0, 0);
        chk("clr_empty", empty0, 1);
        chk("clr_flags2", {ovf0, unf0}, 0);
        chk("clr_rvalid", rvalid0, 0);

        // wrap soak: streaming push/pop holds occupancy at one across pointer wrap
        for (int k = 0; k < 20; k++) begin
            push_word0(16'h0200 + W'(k), 1'b1);
            pop0 = (k > 0);
            step();
            chk("soak_count", count0, 1);
        end
        push0 = 1'b0;
        pop0 = 1'b1;
        step();
        pop0 = 1'b0;
        step();
        chk("soak_empty", empty0, 1);
        chk("soak_flags", {ovf0, unf0}, 0);
        chk("soak_qsize", exp_q0.size(), 0);

        // fall-through instance
        push1 = 1'b1;
        wdata1 = 16'h1234;
        exp_q1.push_back(16'h1234);
        step();
        push1 = 1'b0;
        chk("fwft_rvalid", rvalid1, 1);
        chk("fwft_rdata", rdata1, 16'h1234);
        pop1 = 1'b1;
        step();
        pop1 = 1'b0;
        chk("fwft_pop_rvalid", rvalid1, 0);
        chk("fwft_pop_empty", empty1, 1);

        for (int i = 0; i < 3; i++) begin
            push1 = 1'b1;
            wdata1 = 16'h0A0A + W'(i * 16'h0101);
            exp_q1.push_back(wdata1);
            step();
        end
        push1 = 1'b0;
        chk("fwft_count3", count1, 3);
        chk("fwft_head", rdata1, 16'h0A0A);
        pop1 = 1'b1;
        for (int i = 0; i < 4; i++) step();
        pop1 = 1'b0;
        chk("fwft_unf", unf1, 1);
        chk("fwft_empty", empty1, 1);
        chk("fwft_qsize", exp_q1.size(), 0);
        chk("fwft_ovf", ovf1, 0);

        // asynchronous reset mid-operation discards contents at once
        push1 = 1'b1;
        wdata1 = 16'h5555;
        step();
        push1 = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", count1, 0);
        chk("async_rst_rvalid", rvalid1, 0);
        chk("async_rst_unf", unf1, 0);
        step();
        rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
